// File: rtl/router_reg.sv
// rtl/router_reg.sv - 1x3 router datapath register: header latch, hold byte, running parity and error flags.
// Driven by the router FSM state strobes; dout feeds the addressed output FIFO.

module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] header;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;

  logic header_ok;
  logic parity_byte;

  // Address 3 has no output port, so such a header is never captured.
  assign header_ok   = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign parity_byte = ld_state && !pkt_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      header <= '0;
    end else if (header_ok) begin
      header <= data_in;
    end
  end

  // A byte arriving while the FIFO is full is parked in hold and replayed in LOAD_AFTER_FULL.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
      hold <= '0;
    end else if (lfd_state) begin
      dout <= header;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (ld_state && fifo_full) begin
      hold <= data_in;
    end else if (laf_state) begin
      dout <= hold;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      int_parity <= '0;
    end else if (detect_add) begin
      int_parity <= '0;
    end else if (lfd_state) begin
      int_parity <= int_parity ^ header;
    end else if (ld_state && pkt_valid && !full_state) begin
      int_parity <= int_parity ^ data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_parity <= '0;
    end else if (parity_byte) begin
      pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_done <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end else if ((parity_byte && !fifo_full) ||
                 (laf_state && low_packet_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      low_packet_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_packet_valid <= 1'b0;
    end else if (parity_byte && fifo_full) begin
      low_packet_valid <= 1'b1;
    end
  end

  // err stays visible until the next valid header byte arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (detect_add && pkt_valid) begin
      err <= 1'b0;
    end else if (rst_int_reg && parity_done) begin
      err <= (int_parity != pkt_parity);
    end
  end

endmodule

// File: tb/tb_router_reg.sv
// tb/tb_router_reg.sv - scoreboard bench for router_reg with hand-sequenced FSM strobes.

module tb_router_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       parity_done, low_packet_valid, err;
  logic [7:0] dout;

  always #5 clock = ~clock;

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .err              (err),
    .dout             (dout)
  );

  typedef struct {
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  localparam logic [5:0] IDLE = 6'b000000;
  localparam logic [5:0] DA   = 6'b100000;
  localparam logic [5:0] LFD  = 6'b010000;
  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LAF  = 6'b000100;
  localparam logic [5:0] FUL  = 6'b000010;
  localparam logic [5:0] RST  = 6'b000001;
  localparam logic [7:0] GOOD = 8'h05 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, id, act, want);
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input logic rst, input logic [5:0] st, input logic pv,
                     input logic [7:0] d, input logic ff,
                     input logic [7:0] e_dout, input logic e_pd, input logic e_lpv,
                     input logic e_err);
    reset = rst;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
    @(posedge clock);
    exp_q.push_back('{e_dout, e_pd, e_lpv, e_err, step_no});
    step_no++;
    @(negedge clock);
  endtask

  // Header 05, payload 11 22 33 44, then the given parity byte and the check cycle.
  task automatic pkt(input logic [7:0] prev_dout, input logic [7:0] par, input logic e_err);
    cyc(0, DA,  1, 8'h05, 0, prev_dout, 0, 0, 0);
    cyc(0, LFD, 1, 8'h11, 0, 8'h05,     0, 0, 0);
    cyc(0, LD,  1, 8'h11, 0, 8'h11,     0, 0, 0);
    cyc(0, LD,  1, 8'h22, 0, 8'h22,     0, 0, 0);
    cyc(0, LD,  1, 8'h33, 0, 8'h33,     0, 0, 0);
    cyc(0, LD,  1, 8'h44, 0, 8'h44,     0, 0, 0);
    cyc(0, LD,  0, par,   0, par,       1, 0, 0);
    cyc(0, RST, 0, par,   0, par,       1, 0, e_err);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dout",             e.id, dout,                     e.dout);
        chk("parity_done",      e.id, {7'd0, parity_done},      {7'd0, e.pd});
        chk("low_packet_valid", e.id, {7'd0, low_packet_valid}, {7'd0, e.lpv});
        chk("err",              e.id, {7'd0, err},              {7'd0, e.err});
      end
    end
  end

  initial begin : stimulus
    // reset state
    cyc(1, IDLE, 0, 8'h00, 0, 8'h00, 0, 0, 0);

    // T1 good packet
    pkt(8'h00, GOOD, 0);

    // T2 bad parity, err held until next header
    pkt(GOOD, 8'h56, 1);
    cyc(0, IDLE, 0, 8'h56, 0, 8'h56, 1, 0, 1);

    // T3 FIFO full mid-payload; 22 is diverted to hold and replayed
    cyc(0, DA,  1, 8'h05, 0, 8'h56, 0, 0, 0);
    cyc(0, LFD, 1, 8'h11, 0, 8'h05, 0, 0, 0);
    cyc(0, LD,  1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc(0, LD,  1, 8'h22, 1, 8'h11, 0, 0, 0);
    cyc(0, FUL, 1, 8'h33, 1, 8'h11, 0, 0, 0);
    cyc(0, LAF, 1, 8'h33, 0, 8'h22, 0, 0, 0);
    cyc(0, LD,  1, 8'h33, 0, 8'h33, 0, 0, 0);
    cyc(0, LD,  1, 8'h44, 0, 8'h44, 0, 0, 0);
    cyc(0, LD,  0, GOOD,  0, GOOD,  1, 0, 0);
    cyc(0, RST, 0, GOOD,  0, GOOD,  1, 0, 0);

    // T4 FIFO full on parity byte 55 (mismatches GOOD)
    cyc(0, DA,  1, 8'h05, 0, GOOD,  0, 0, 0);
    cyc(0, LFD, 1, 8'h11, 0, 8'h05, 0, 0, 0);
    cyc(0, LD,  1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc(0, LD,  1, 8'h22, 0, 8'h22, 0, 0, 0);
    cyc(0, LD,  1, 8'h33, 0, 8'h33, 0, 0, 0);
    cyc(0, LD,  1, 8'h44, 0, 8'h44, 0, 0, 0);
    cyc(0, LD,  0, 8'h55, 1, 8'h44, 0, 1, 0);
    cyc(0, FUL, 0, 8'h55, 1, 8'h44, 0, 1, 0);
    cyc(0, LAF, 0, 8'h55, 0, 8'h55, 1, 1, 0);
    cyc(0, RST, 0, 8'h55, 0, 8'h55, 1, 0, 1);

    // T5 address 3 not latched; LFD then shows the old header; zero-payload packet
    cyc(0, DA,  1, 8'h07, 0, 8'h55, 0, 0, 0);
    cyc(0, LFD, 1, 8'h07, 0, 8'h05, 0, 0, 0);
    cyc(0, LD,  0, 8'h05, 0, 8'h05, 1, 0, 0);
    cyc(0, RST, 0, 8'h05, 0, 8'h05, 1, 0, 0);

    // T6 mid-packet reset, then a fresh good packet
    cyc(0, DA,  1, 8'h09, 0, 8'h05, 0, 0, 0);
    cyc(0, LFD, 1, 8'h11, 0, 8'h09, 0, 0, 0);
    cyc(0, LD,  1, 8'h11, 0, 8'h11, 0, 0, 0);
    cyc(0, LD,  1, 8'h22, 0, 8'h22, 0, 0, 0);
    cyc(1, LD,  1, 8'h33, 0, 8'h00, 0, 0, 0);
    cyc(0, LFD, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    pkt(8'h00, GOOD, 0);

    // detect_add clear beats a same-cycle parity_done set
    cyc(0, DA | LD, 0, 8'h77, 0, 8'h77, 0, 0, 0);
    cyc(0, IDLE,    0, 8'h00, 0, 8'h77, 0, 0, 0);

    @(posedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
